// File: rtl/spm_port_arbiter_pkg.sv
// Shared encodings for the SPM port-B arbiter: strobe/direction polarities and FSM states.
// Optional feature macro used by the arbiter: SPM_PORT_ARBITER_LOCK_EN.
package spm_port_arbiter_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int SPM_ARB_STATE_W = 2;

    typedef enum logic [SPM_ARB_STATE_W-1:0] {
        SPM_ARB_IDLE  = 2'd0,
        SPM_ARB_BUSY0 = 2'd1,
        SPM_ARB_BUSY1 = 2'd2
    } spm_arb_state_e;

endpackage

// File: rtl/spm_port_arbiter_if.sv
// Bundle of both requester ports and the SPM port-B side of the arbiter.
// slave = arbiter view; master = requesters plus SPM (the surrounding system).
interface spm_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              m0_as_;
    logic              m0_rw;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic [DATA_W-1:0] m0_rd_data;
    logic              m0_rdy_;

    logic              m1_as_;
    logic              m1_rw;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic [DATA_W-1:0] m1_rd_data;
    logic              m1_rdy_;
    logic              m1_lock_;

    logic              spm_as_;
    logic              spm_rw;
    logic [ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0] spm_wr_data;
    logic [DATA_W-1:0] spm_rd_data;

    modport slave (
        input  m0_as_, m0_rw, m0_addr, m0_wr_data,
        output m0_rd_data, m0_rdy_,
        input  m1_as_, m1_rw, m1_addr, m1_wr_data, m1_lock_,
        output m1_rd_data, m1_rdy_,
        output spm_as_, spm_rw, spm_addr, spm_wr_data,
        input  spm_rd_data
    );

    modport master (
        output m0_as_, m0_rw, m0_addr, m0_wr_data,
        input  m0_rd_data, m0_rdy_,
        output m1_as_, m1_rw, m1_addr, m1_wr_data, m1_lock_,
        input  m1_rd_data, m1_rdy_,
        input  spm_as_, spm_rw, spm_addr, spm_wr_data,
        output spm_rd_data
    );

endinterface

// File: rtl/spm_port_arbiter.sv
// Shares SPM port B between the MEM stage (m0, priority) and the bus slave (m1); one access per cycle.
// Latency: issue same cycle as grant, rdy_/rd_data one cycle later; the completing requester is
// excluded so the two alternate. SPM_PORT_ARBITER_LOCK_EN adds an m1 bus-lock that holds off m0.
module spm_port_arbiter
    import spm_port_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset_,
    spm_port_arbiter_if.slave   bus
);

    spm_arb_state_e state_q, state_d;
    logic           elig0, elig1;
    logic           grant0, grant1;

`ifdef SPM_PORT_ARBITER_LOCK_EN
    logic lock_q, lock_d;
`else
    logic unused_lock;
    assign unused_lock = bus.m1_lock_;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= SPM_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SPM_PORT_ARBITER_LOCK_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    // Grants are gated by reset_ so the port is released the instant reset asserts.
    always_comb begin
        elig0 = reset_ && (bus.m0_as_ == ENABLE_) && (state_q != SPM_ARB_BUSY0);
        elig1 = reset_ && (bus.m1_as_ == ENABLE_) && (state_q != SPM_ARB_BUSY1);
`ifdef SPM_PORT_ARBITER_LOCK_EN
        elig0 = elig0 && !lock_q;
`endif
        grant0 = elig0;
        grant1 = elig1 && !elig0;

        state_d = SPM_ARB_IDLE;
        if (grant0) begin
            state_d = SPM_ARB_BUSY0;
        end else if (grant1) begin
            state_d = SPM_ARB_BUSY1;
        end

`ifdef SPM_PORT_ARBITER_LOCK_EN
        lock_d = lock_q;
        if (lock_q && (bus.m1_lock_ != ENABLE_) && (state_q != SPM_ARB_BUSY1)) begin
            lock_d = 1'b0;
        end
        if (grant1 && (bus.m1_lock_ == ENABLE_)) begin
            lock_d = 1'b1;
        end
`endif
    end

    always_comb begin
        bus.spm_as_     = DISABLE_;
        bus.spm_rw      = READ;
        bus.spm_addr    = '0;
        bus.spm_wr_data = '0;
        bus.m0_rdy_     = DISABLE_;
        bus.m0_rd_data  = '0;
        bus.m1_rdy_     = DISABLE_;
        bus.m1_rd_data  = '0;

        if (grant0) begin
            bus.spm_as_     = ENABLE_;
            bus.spm_rw      = bus.m0_rw;
            bus.spm_addr    = bus.m0_addr;
            bus.spm_wr_data = bus.m0_wr_data;
        end else if (grant1) begin
            bus.spm_as_     = ENABLE_;
            bus.spm_rw      = bus.m1_rw;
            bus.spm_addr    = bus.m1_addr;
            bus.spm_wr_data = bus.m1_wr_data;
        end

        // Completion is a pure function of state: the access issued last cycle returns now.
        if (state_q == SPM_ARB_BUSY0) begin
            bus.m0_rdy_    = ENABLE_;
            bus.m0_rd_data = bus.spm_rd_data;
        end
        if (state_q == SPM_ARB_BUSY1) begin
            bus.m1_rdy_    = ENABLE_;
            bus.m1_rd_data = bus.spm_rd_data;
        end
    end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Directed bench for spm_port_arbiter: request queues per requester, an SPM memory, and a
// reference model of the arbitration rules checked every cycle, plus literal per-test expectations.
module tb_spm_port_arbiter;
    import spm_port_arbiter_pkg::*;

    typedef struct {
        logic        rw;
        logic        lk;
        logic [11:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic        rw;
    } iss_t;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    spm_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    spm_port_arbiter dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPM: synchronous read; a write also returns the written word.
    logic [31:0] mem [4096];
    logic [31:0] spm_rd_q = '0;
    assign bus.spm_rd_data = spm_rd_q;
    always @(posedge clk) begin
        if (bus.spm_as_ == ENABLE_) begin
            if (bus.spm_rw == WRITE) begin
                mem[bus.spm_addr] <= bus.spm_wr_data;
                spm_rd_q          <= bus.spm_wr_data;
            end else begin
                spm_rd_q <= mem[bus.spm_addr];
            end
        end
    end

    op_t  q0[$], q1[$];
    logic done0 = 1'b0, done1 = 1'b0;
    iss_t iss[$];
    int   rcyc0[$], rcyc1[$];
    logic [31:0] rdat0[$], rdat1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Requester m0: holds its front op until rdy_ pulses, then moves on.
    initial begin : agent0
        bus.m0_as_ = DISABLE_; bus.m0_rw = READ; bus.m0_addr = '0; bus.m0_wr_data = '0;
        forever begin
            @(posedge clk); #2;
            if (done0) begin
                if (q0.size() > 0) void'(q0.pop_front());
                done0 = 1'b0;
            end
            if (reset_ && q0.size() > 0) begin
                bus.m0_as_ = ENABLE_; bus.m0_rw = q0[0].rw;
                bus.m0_addr = q0[0].addr; bus.m0_wr_data = q0[0].data;
            end else begin
                bus.m0_as_ = DISABLE_;
            end
        end
    end

    initial begin : agent1
        bus.m1_as_ = DISABLE_; bus.m1_rw = READ; bus.m1_addr = '0; bus.m1_wr_data = '0;
        bus.m1_lock_ = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (done1) begin
                if (q1.size() > 0) void'(q1.pop_front());
                done1 = 1'b0;
            end
            if (reset_ && q1.size() > 0) begin
                bus.m1_as_ = ENABLE_; bus.m1_rw = q1[0].rw; bus.m1_lock_ = q1[0].lk;
                bus.m1_addr = q1[0].addr; bus.m1_wr_data = q1[0].data;
            end else begin
                bus.m1_as_ = DISABLE_; bus.m1_lock_ = 1'b1;
            end
        end
    end

    // Reference model: who issued last cycle (pend), what it must return, and the lock flag.
    logic [31:0] ref_mem [4096];
    int          pend = -1;
    logic [31:0] pend_data = '0;
    logic        mlock = 1'b0;

    always @(negedge clk) begin : cmp
        int          g;
        logic        erw;
        logic [11:0] ea;
        logic [31:0] ewd;
        if (!reset_) begin
            chk("rst_spm_as", bus.spm_as_, DISABLE_);
            chk("rst_m0_rdy", bus.m0_rdy_, DISABLE_);
            chk("rst_m1_rdy", bus.m1_rdy_, DISABLE_);
            chk("rst_m0_rd", bus.m0_rd_data, 32'h0);
            chk("rst_m1_rd", bus.m1_rd_data, 32'h0);
            pend  = -1;
            mlock = 1'b0;
        end else begin
            chk("m0_rdy", bus.m0_rdy_, (pend == 0) ? ENABLE_ : DISABLE_);
            chk("m1_rdy", bus.m1_rdy_, (pend == 1) ? ENABLE_ : DISABLE_);
            chk("m0_rd", bus.m0_rd_data, (pend == 0) ? pend_data : 32'h0);
            chk("m1_rd", bus.m1_rd_data, (pend == 1) ? pend_data : 32'h0);
            if (!bus.m0_rdy_) begin rcyc0.push_back(cyc); rdat0.push_back(bus.m0_rd_data); done0 = 1'b1; end
            if (!bus.m1_rdy_) begin rcyc1.push_back(cyc); rdat1.push_back(bus.m1_rd_data); done1 = 1'b1; end

            g = -1;
            if (bus.m0_as_ == ENABLE_ && pend != 0 && !mlock) g = 0;
            else if (bus.m1_as_ == ENABLE_ && pend != 1) g = 1;
            erw = (g == 0) ? bus.m0_rw : (g == 1) ? bus.m1_rw : READ;
            ea  = (g == 0) ? bus.m0_addr : (g == 1) ? bus.m1_addr : 12'h0;
            ewd = (g == 0) ? bus.m0_wr_data : (g == 1) ? bus.m1_wr_data : 32'h0;
            chk("spm_as", bus.spm_as_, (g >= 0) ? ENABLE_ : DISABLE_);
            chk("spm_rw", bus.spm_rw, erw);
            chk("spm_addr", bus.spm_addr, ea);
            chk("spm_wr_data", bus.spm_wr_data, ewd);
            if (!bus.spm_as_) iss.push_back('{cyc, bus.spm_addr, bus.spm_rw});

`ifdef SPM_PORT_ARBITER_LOCK_EN
            if (mlock && bus.m1_lock_ && pend != 1) mlock = 1'b0;
            if (g == 1 && !bus.m1_lock_) mlock = 1'b1;
`endif
            if (g >= 0) begin
                if (erw == WRITE) ref_mem[ea] = ewd;
                pend_data = ref_mem[ea];
            end
            pend = g;
        end
    end

    task automatic clear_logs();
        iss.delete(); rcyc0.delete(); rcyc1.delete(); rdat0.delete(); rdat1.delete();
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk); n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(nm, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_issue(input string nm);
        int n = 0;
        while (iss.size() == 0 && n < 50) begin
            @(posedge clk); n++;
        end
        chk(nm, (n < 50) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : main
        int rel;
        logic [11:0] exp_a [4];
        for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_spm_as_lit", bus.spm_as_, 1'b1);
        @(posedge clk); #1 reset_ = 1'b1;
        repeat (2) @(posedge clk); #1;

        // 1: single m0 read
        clear_logs();
        q0.push_back('{READ, 1'b1, 12'h010, 32'h0});
        wait_done("t1_timeout");
        chk("t1_n_issue", iss.size(), 1);
        chk("t1_n_rdy", rcyc0.size(), 1);
        if (iss.size() == 1 && rcyc0.size() == 1) begin
            chk("t1_addr", iss[0].addr, 12'h010);
            chk("t1_lat", rcyc0[0] - iss[0].cyc, 1);
            chk("t1_data", rdat0[0], 32'hDEADBEEF);
        end

        // 2: simultaneous requests
        clear_logs();
        q0.push_back('{READ, 1'b1, 12'h100, 32'h0});
        q1.push_back('{READ, 1'b1, 12'h200, 32'h0});
        wait_done("t2_timeout");
        chk("t2_n_issue", iss.size(), 2);
        if (iss.size() == 2 && rcyc0.size() == 1 && rcyc1.size() == 1) begin
            chk("t2_first", iss[0].addr, 12'h100);
            chk("t2_second", iss[1].addr, 12'h200);
            chk("t2_m1_grant", iss[1].cyc - iss[0].cyc, 1);
            chk("t2_m0_rdy", rcyc0[0] - iss[0].cyc, 1);
            chk("t2_m1_rdy", rcyc1[0] - iss[0].cyc, 2);
        end

        // 3: sustained contention alternates with no idle port cycles
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            q0.push_back('{READ, 1'b1, 12'h300 + 12'(i), 32'h0});
            q1.push_back('{READ, 1'b1, 12'h400 + 12'(i), 32'h0});
        end
        wait_done("t3_timeout");
        chk("t3_n_issue", iss.size(), 10);
        for (int i = 1; i < iss.size(); i++) begin
            chk("t3_back_to_back", iss[i].cyc - iss[i-1].cyc, 1);
            chk("t3_alternate", {28'h0, iss[i].addr[11:8]}, (i % 2 == 0) ? 32'd3 : 32'd4);
        end

        // 4: m1 write then m0 read of the same word
        clear_logs();
        q1.push_back('{WRITE, 1'b1, 12'h0A5, 32'h12345678});
        wait_done("t4w_timeout");
        q0.push_back('{READ, 1'b1, 12'h0A5, 32'h0});
        wait_done("t4r_timeout");
        chk("t4_n_rdy", rdat0.size(), 1);
        if (rdat0.size() == 1) chk("t4_data", rdat0[0], 32'h12345678);

        // 5: reset in the cycle m1's completion is due
        clear_logs();
        q1.push_back('{READ, 1'b1, 12'h0A5, 32'h0});
        wait_issue("t5_issue_timeout");
        #1 reset_ = 1'b0;
        q1.delete();
        #1;
        chk("t5_spm_as_immediate", bus.spm_as_, 1'b1);
        chk("t5_m1_rdy_immediate", bus.m1_rdy_, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset_ = 1'b1;
        rel = cyc;
        chk("t5_no_rdy", rcyc1.size(), 0);
        clear_logs();
        q1.push_back('{READ, 1'b1, 12'h0A5, 32'h0});
        wait_done("t5_timeout");
        if (iss.size() == 1 && rdat1.size() == 1) begin
            chk("t5_grant_after_release", iss[0].cyc, rel);
            chk("t5_data", rdat1[0], 32'h12345678);
        end else begin
            chk("t5_n_issue", iss.size(), 1);
        end

        // 6: locked read-modify-write by m1 with m0 contending
        clear_logs();
        q1.push_back('{READ, 1'b0, 12'h020, 32'h0});
        q1.push_back('{WRITE, 1'b0, 12'h020, 32'hCAFE0001});
        wait_issue("t6_issue_timeout");
        #1;
        q0.push_back('{READ, 1'b1, 12'h030, 32'h0});
        q0.push_back('{READ, 1'b1, 12'h031, 32'h0});
        wait_done("t6_timeout");
`ifdef SPM_PORT_ARBITER_LOCK_EN
        exp_a = '{12'h020, 12'h020, 12'h030, 12'h031};
`else
        exp_a = '{12'h020, 12'h030, 12'h020, 12'h031};
`endif
        chk("t6_n_issue", iss.size(), 4);
        for (int i = 0; i < 4 && i < iss.size(); i++) begin
            chk("t6_order", iss[i].addr, exp_a[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
